// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared immediate-format encodings and XLEN legality helper
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_RSV = 3'b111;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RISC-V immediate decoder, sign/zero extended to XLEN
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] immext,
  output logic            err
);

  if (!xlen_legal(XLEN)) begin : g_xlen_chk
    $error("imm_decode: XLEN must be 32 or 64");
  end

  // Opcode field never contributes to any immediate
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  logic [31:0] sext32;
  logic [5:0]  uimm;
  logic        use_sext;

  // Build a 32-bit sign-extended value or a small unsigned value, then widen to XLEN
  always_comb begin
    sext32   = '0;
    uimm     = '0;
    use_sext = 1'b0;
    err      = 1'b0;
    immext   = '0;
    case (immsrc)
      IMM_I: begin
        sext32   = {{20{instr[31]}}, instr[31:20]};
        use_sext = 1'b1;
      end
      IMM_S: begin
        sext32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        use_sext = 1'b1;
      end
      IMM_B: begin
        sext32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        use_sext = 1'b1;
      end
      IMM_J: begin
        sext32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        use_sext = 1'b1;
      end
      IMM_U: begin
        sext32   = {instr[31:12], 12'b0};
        use_sext = 1'b1;
      end
      IMM_Z: begin
        uimm = {1'b0, instr[19:15]};
      end
      IMM_SH: begin
        uimm = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
      end
      default: begin
        err = 1'b1;
      end
    endcase
    if (use_sext) begin
      immext = XLEN'($signed(sext32));
    end else begin
      immext = XLEN'(uimm);
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with valid/ready skid buffer and flush
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_err
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr  (instr),
    .immsrc (immsrc),
    .immext (dec_imm),
    .err    (dec_err)
  );

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_err_q,   main_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_err_q,   skid_err_d;

  logic in_fire;
  logic main_open;

  // in_ready comes straight from the skid flop so out_ready never reaches it combinationally
  assign in_ready  = !skid_valid_q;
  assign in_fire   = in_valid && !skid_valid_q;
  assign main_open = !main_valid_q || out_ready;

  // Next-state for main/skid: flush drops both valids, otherwise FIFO refill from skid then input
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_open) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_tag_d   = skid_tag_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_tag_d   = in_tag;
        main_err_d   = dec_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tag_d   = in_tag;
      skid_err_d   = dec_err;
    end
  end

  // State registers; reset clears valids and payloads so outputs read zero
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign out_valid = main_valid_q;
  assign immext    = main_imm_q;
  assign out_tag   = main_tag_q;
  assign imm_err   = main_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed table-driven bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, imm_err32;
  logic [31:0] immext32, out_tag32;
  logic        in_ready64, out_valid64, imm_err64;
  logic [63:0] immext64;
  logic [31:0] out_tag64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .immext(immext32), .out_tag(out_tag32), .imm_err(imm_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .immext(immext64), .out_tag(out_tag64), .imm_err(imm_err64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
    in_valid = v;
    instr    = ins;
    immsrc   = src;
    in_tag   = tag;
  endtask

  initial begin
    vecs[0] = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2] = '{32'hFE000EE3, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[3] = '{32'hFE112E23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[4] = '{32'h0080006F, 3'b011, 32'h00000008, 64'h0000000000000008, 1'b0};
    vecs[5] = '{32'h12345037, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[6] = '{32'h3E0F9073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[7] = '{32'h03F01013, 3'b110, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vecs[8] = '{32'h7FF00093, 3'b000, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[9] = '{32'h800000B7, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};

    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'b000, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("reset_immext", {32'b0, immext32}, 64'd0);
    chk("reset_out_tag", {32'b0, out_tag32}, 64'd0);
    chk("reset_imm_err", {63'b0, imm_err32}, 64'd0);
    chk("reset_in_ready", {63'b0, in_ready32}, 64'd1);
    chk("reset_immext64", immext64, 64'd0);

    // Back-to-back stream, out_ready=1: each entry appears one cycle after transfer
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].immsrc, 32'h100 + i);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {63'b0, out_valid32}, 64'd1);
      chk($sformatf("vec%0d_imm32", i), {32'b0, immext32}, {32'b0, vecs[i].exp32});
      chk($sformatf("vec%0d_err32", i), {63'b0, imm_err32}, {63'b0, vecs[i].err});
      chk($sformatf("vec%0d_tag", i), {32'b0, out_tag32}, {32'b0, 32'h100 + i});
      chk($sformatf("vec%0d_imm64", i), immext64, vecs[i].exp64);
      chk($sformatf("vec%0d_err64", i), {63'b0, imm_err64}, {63'b0, vecs[i].err});
    end
    drive(1'b0, 32'h0, 3'b000, 32'h0);
    @(negedge clk);
    chk("idle_out_valid", {63'b0, out_valid32}, 64'd0);

    // Stall: A held in main, B in skid, C held upstream, then A,B,C drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 32'hA);
    @(negedge clk);
    chk("stall_a_valid", {63'b0, out_valid32}, 64'd1);
    chk("stall_a_ready", {63'b0, in_ready32}, 64'd1);
    drive(1'b1, 32'h7FF00093, 3'b000, 32'hB);
    @(negedge clk);
    chk("stall_b_in_ready", {63'b0, in_ready32}, 64'd0);
    chk("stall_hold_tag", {32'b0, out_tag32}, 64'hA);
    drive(1'b1, 32'h12345037, 3'b100, 32'hC);
    @(negedge clk);
    chk("stall_c_in_ready", {63'b0, in_ready32}, 64'd0);
    chk("stall_hold_imm", {32'b0, immext32}, 64'hFFFFFFFF);
    chk("stall_hold_tag2", {32'b0, out_tag32}, 64'hA);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_b_tag", {32'b0, out_tag32}, 64'hB);
    chk("drain_b_imm", {32'b0, immext32}, 64'h7FF);
    chk("drain_b_in_ready", {63'b0, in_ready32}, 64'd1);
    @(negedge clk);
    chk("drain_c_tag", {32'b0, out_tag32}, 64'hC);
    chk("drain_c_imm", {32'b0, immext32}, 64'h12345000);
    drive(1'b0, 32'h0, 3'b000, 32'h0);
    @(negedge clk);
    chk("drain_empty", {63'b0, out_valid32}, 64'd0);

    // Flush with both entries full and a pending input
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 32'h11);
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 3'b000, 32'h12);
    @(negedge clk);
    chk("preflush_full", {63'b0, in_ready32}, 64'd0);
    drive(1'b1, 32'hFFF00093, 3'b000, 32'hDD);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 32'h0);
    chk("flush_full_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("flush_full_in_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flush_full_no_ghost", {63'b0, out_valid32}, 64'd0);
    end

    // Flush while in_ready=1: the simultaneous input is discarded too
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 32'h21);
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 3'b000, 32'hEE);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 32'h0);
    chk("flush_half_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("flush_half_in_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flush_half_no_ghost", {63'b0, out_valid32}, 64'd0);
    end

    // Reset mid-stream, then a fresh zimm decode
    out_ready = 1'b0;
    drive(1'b1, 32'hFE000EE3, 3'b111, 32'h31);
    @(negedge clk);
    drive(1'b1, 32'hFE000EE3, 3'b010, 32'h32);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 32'h0);
    chk("rst_mid_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("rst_mid_immext", {32'b0, immext32}, 64'd0);
    chk("rst_mid_imm_err", {63'b0, imm_err32}, 64'd0);
    chk("rst_mid_in_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    drive(1'b1, 32'h3E0F9073, 3'b101, 32'h40);
    @(negedge clk);
    drive(1'b0, 32'h0, 3'b000, 32'h0);
    chk("post_rst_valid", {63'b0, out_valid32}, 64'd1);
    chk("post_rst_zimm", {32'b0, immext32}, 64'h1F);
    chk("post_rst_tag", {32'b0, out_tag32}, 64'h40);
    chk("post_rst_zimm64", immext64, 64'h1F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
